// File: rtl/ysyx_2022040010_dsram_axil_pkg.sv
// Shared definitions for the data-SRAM AXI4-Lite bridge.
//   - state_e     : bridge FSM state encoding
//   - RESP_OKAY   : AXI response code for a successful beat
//   - DEF_ADDR_W / DEF_DATA_W : default core/bus widths of this stage
//   - resp_is_err : classifies a BRESP/RRESP value as an error
package ysyx_2022040010_dsram_axil_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Any response other than OKAY terminates the access with an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_2022040010_dsram_axil_if.sv
// AXI4-Lite bundle between the data-SRAM bridge (master) and a memory
// slave. Carries the AW, W, B, AR and R channels.
//   master : drives valids/addresses/write data and the B/R readies
//   slave  : drives the AW/W/AR readies and the B/R responses
interface ysyx_2022040010_dsram_axil_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/ysyx_2022040010_dsram_axil.sv
// Data-SRAM to AXI4-Lite bridge. Turns a single-cycle core load/store
// request into one AXI4-Lite transaction, stalling the pipeline until
// the transaction finishes.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   dsram_e/_we  : request strobe and direction (1 = write)
//   dsram_addr   : access address;  dsram_wdata : store data
//   dsram_rdata  : last load data (held until the next load completes)
//   stall_req    : holds the core while a request is pending/in flight
//   bus_err      : one-cycle pulse when the access got a non-OKAY response
//   axi          : AXI4-Lite master port
module ysyx_2022040010_dsram_axil
    import ysyx_2022040010_dsram_axil_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dsram_e,
    input  logic                dsram_we,
    input  logic [ADDR_W-1:0]   dsram_addr,
    input  logic [DATA_W-1:0]   dsram_wdata,
    output logic [DATA_W-1:0]   dsram_rdata,
    output logic                stall_req,
    output logic                bus_err,
    ysyx_2022040010_dsram_axil_if.master axi
);

    state_e              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                arvalid_r;
    logic                rready_r;
    logic                awvalid_r;
    logic                wvalid_r;
    logic                bready_r;
    logic                aw_done_r;
    logic                w_done_r;
    logic                bus_err_r;
    logic                aw_fire_s;
    logic                w_fire_s;
    logic                stall_s;

    assign aw_fire_s = awvalid_r & axi.awready;
    assign w_fire_s  = wvalid_r & axi.wready;

    // Access FSM; every AXI valid/ready output is a register set on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            wdata_r   <= '0;
            rdata_r   <= '0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dsram_e) begin
                        addr_r  <= dsram_addr;
                        wdata_r <= dsram_wdata;
                        if (dsram_we) begin
                            state_r   <= ST_WR_REQ;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                        end else begin
                            state_r   <= ST_RD_ADDR;
                            arvalid_r <= 1'b1;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // Data is captured even on an error response.
                    if (axi.rvalid) begin
                        rready_r  <= 1'b0;
                        rdata_r   <= axi.rdata;
                        bus_err_r <= resp_is_err(axi.rresp);
                        state_r   <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently, in either order.
                    if (aw_fire_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_fire_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r | aw_fire_s) & (w_done_r | w_fire_s)) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_r  <= 1'b0;
                        bus_err_r <= resp_is_err(axi.bresp);
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Single turnaround cycle; a request seen here waits for IDLE.
                    bus_err_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    bus_err_r <= 1'b0;
                end
            endcase
        end
    end

    // Stall while a request waits in IDLE or any bus phase is in flight.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE:    stall_s = dsram_e;
            ST_RD_ADDR: stall_s = 1'b1;
            ST_RD_DATA: stall_s = 1'b1;
            ST_WR_REQ:  stall_s = 1'b1;
            ST_WR_RESP: stall_s = 1'b1;
            default:    stall_s = 1'b0;
        endcase
    end

    assign stall_req   = stall_s;
    assign bus_err     = bus_err_r;
    assign dsram_rdata = rdata_r;

    assign axi.arvalid = arvalid_r;
    assign axi.araddr  = addr_r;
    assign axi.rready  = rready_r;
    assign axi.awvalid = awvalid_r;
    assign axi.awaddr  = addr_r;
    assign axi.wvalid  = wvalid_r;
    assign axi.wdata   = wdata_r;
    assign axi.wstrb   = {(DATA_W/8){1'b1}};
    assign axi.bready  = bready_r;

endmodule

// File: tb/tb_ysyx_2022040010_dsram_axil.sv
// Self-checking bench for the data-SRAM AXI4-Lite bridge. The slave is a
// cycle schedule: for each access the bench picks handshake delays, and the
// expected per-cycle outputs follow from those delays with plain arithmetic.
module tb_ysyx_2022040010_dsram_axil;

    logic        clk;
    logic        rst;
    logic        dsram_e;
    logic        dsram_we;
    logic [63:0] dsram_addr;
    logic [63:0] dsram_wdata;
    logic [63:0] dsram_rdata;
    logic        stall_req;
    logic        bus_err;

    int n_cmp;
    int n_fail;
    logic [63:0] model_rdata;

    ysyx_2022040010_dsram_axil_if #(.ADDR_W(64), .DATA_W(64)) axi ();

    ysyx_2022040010_dsram_axil #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .dsram_e     (dsram_e),
        .dsram_we    (dsram_we),
        .dsram_addr  (dsram_addr),
        .dsram_wdata (dsram_wdata),
        .dsram_rdata (dsram_rdata),
        .stall_req   (stall_req),
        .bus_err     (bus_err),
        .axi         (axi)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 64'h0;
        axi.rresp   = 2'b00;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".arvalid"}, {63'h0, axi.arvalid}, 64'h0);
        check({tag, ".rready"},  {63'h0, axi.rready},  64'h0);
        check({tag, ".awvalid"}, {63'h0, axi.awvalid}, 64'h0);
        check({tag, ".wvalid"},  {63'h0, axi.wvalid},  64'h0);
        check({tag, ".bready"},  {63'h0, axi.bready},  64'h0);
        check({tag, ".bus_err"}, {63'h0, bus_err},     64'h0);
        check({tag, ".rdata"},   dsram_rdata,          model_rdata);
    endtask

    // One cycle with no request: the bridge must be idle and silent.
    task automatic idle_cycle();
        dsram_e    = 1'b0;
        dsram_we   = 1'($urandom);
        dsram_addr = {$urandom, $urandom};
        #1;
        check("idle.stall", {63'h0, stall_req}, 64'h0);
        check_quiet("idle");
        @(posedge clk); #1;
    endtask

    // One access, starting in the IDLE cycle that accepts it and ending with
    // the DONE cycle. Read: d1 = cycles arvalid waits for arready, d2 = cycles
    // with rready high (rvalid in the last). Write: d1/d2 = AW/W wait cycles,
    // d3 = cycles with bready high (bvalid in the last).
    task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] data,
                       input logic [1:0] resp, input int d1, input int d2, input int d3);
        int a_len;
        int d_cyc;
        logic e_arv, e_rr, e_awv, e_wv, e_br;
        a_len = ((d1 > d2) ? d1 : d2) + 1;
        d_cyc = we ? (1 + a_len + d3) : (2 + d1 + d2);
        dsram_e     = 1'b1;
        dsram_we    = we;
        dsram_addr  = addr;
        dsram_wdata = we ? data : {$urandom, $urandom};
        for (int c = 0; c <= d_cyc; c++) begin
            if (c > 0) begin
                // Core inputs wander while the access is in flight.
                dsram_we    = 1'($urandom);
                dsram_addr  = {$urandom, $urandom};
                dsram_wdata = {$urandom, $urandom};
            end
            axi.arready = !we && (c == 1 + d1);
            axi.rvalid  = !we && (c == 1 + d1 + d2);
            axi.rdata   = (!we && (c == 1 + d1 + d2)) ? data : {$urandom, $urandom};
            axi.rresp   = resp;
            axi.awready = we && (c == 1 + d1);
            axi.wready  = we && (c == 1 + d2);
            axi.bvalid  = we && (c == a_len + d3);
            axi.bresp   = resp;
            #1;
            e_arv = !we && (c >= 1) && (c <= 1 + d1);
            e_rr  = !we && (c >= 2 + d1) && (c <= 1 + d1 + d2);
            e_awv = we && (c >= 1) && (c <= 1 + d1);
            e_wv  = we && (c >= 1) && (c <= 1 + d2);
            e_br  = we && (c >= 1 + a_len) && (c <= a_len + d3);
            check("stall_req", {63'h0, stall_req},   {63'h0, (c < d_cyc)});
            check("arvalid",   {63'h0, axi.arvalid}, {63'h0, e_arv});
            check("rready",    {63'h0, axi.rready},  {63'h0, e_rr});
            check("awvalid",   {63'h0, axi.awvalid}, {63'h0, e_awv});
            check("wvalid",    {63'h0, axi.wvalid},  {63'h0, e_wv});
            check("bready",    {63'h0, axi.bready},  {63'h0, e_br});
            if (e_arv) check("araddr", axi.araddr, addr);
            if (e_awv) check("awaddr", axi.awaddr, addr);
            if (e_wv) begin
                check("wdata", axi.wdata, data);
                check("wstrb", {56'h0, axi.wstrb}, 64'hFF);
            end
            check("bus_err", {63'h0, bus_err}, {63'h0, ((c == d_cyc) && (resp != 2'b00))});
            if (c == d_cyc) begin
                if (!we) model_rdata = data;
                check("dsram_rdata", dsram_rdata, model_rdata);
            end
            @(posedge clk); #1;
        end
        clear_slave();
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        model_rdata = 64'h0;
        rst         = 1'b1;
        dsram_e     = 1'b0;
        dsram_we    = 1'b0;
        dsram_addr  = 64'h0;
        dsram_wdata = 64'h0;
        clear_slave();
        repeat (2) @(posedge clk);
        #1;
        check("reset.stall", {63'h0, stall_req}, 64'h0);
        check_quiet("reset");
        rst = 1'b0;
        idle_cycle();

        // Zero-wait read: three stall cycles, then DONE with the data.
        txn(1'b0, 64'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 0, 1, 0);
        idle_cycle();

        // Write with W accepted two cycles ahead of AW.
        txn(1'b1, 64'h8000_0020, 64'hDEAD_BEEF_0000_0001, 2'b00, 2, 0, 1);
        idle_cycle();

        // Zero-wait write: three stall cycles.
        txn(1'b1, 64'h8000_0028, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 1);
        idle_cycle();

        // Slow read: arvalid waits 4 cycles, rvalid arrives on the 3rd rready cycle.
        txn(1'b0, 64'h8000_0030, 64'hCAFE_F00D_1234_5678, 2'b00, 4, 3, 0);
        idle_cycle();

        // Write error response, then a read error that still returns data.
        txn(1'b1, 64'h8000_0040, 64'h5555_AAAA_5555_AAAA, 2'b10, 1, 1, 2);
        idle_cycle();
        txn(1'b0, 64'h8000_0048, 64'h0F0F_0F0F_F0F0_F0F0, 2'b11, 1, 2, 0);
        idle_cycle();

        // Reset while waiting for read data aborts the access.
        dsram_e    = 1'b1;
        dsram_we   = 1'b0;
        dsram_addr = 64'h8000_0050;
        @(posedge clk); #1;
        axi.arready = 1'b1;
        @(posedge clk); #1;
        clear_slave();
        check("rst_mid.rready_before", {63'h0, axi.rready}, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        dsram_e     = 1'b0;
        model_rdata = 64'h0;
        check("rst_mid.stall", {63'h0, stall_req}, 64'h0);
        check_quiet("rst_mid");
        idle_cycle();

        // Back-to-back read then write with the request held high.
        txn(1'b0, 64'h8000_0060, 64'h7777_6666_5555_4444, 2'b00, 0, 1, 0);
        txn(1'b1, 64'h8000_0068, 64'h1111_2222_3333_4444, 2'b00, 1, 0, 1);
        idle_cycle();

        // Randomized accesses, sometimes back-to-back.
        for (int i = 0; i < 24; i++) begin
            logic        r_we;
            logic [1:0]  r_resp;
            r_we   = 1'($urandom);
            r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            txn(r_we, {$urandom, $urandom}, {$urandom, $urandom}, r_resp,
                $urandom_range(0, 3), r_we ? $urandom_range(0, 3) : $urandom_range(1, 4),
                $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_2022040010_dsram_axil.md
YSYX_2022040010_DSRAM_AXIL -- requirements
Module: ysyx_2022040010_dsram_axil

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width of core and bus.
REQ-002 SHALL have parameter DATA_W, default 64, data width (multiple of 8).
REQ-003 SHALL have ports clk input 1, the single clock, and rst input 1, synchronous active-high reset.
REQ-004 SHALL have core-side inputs:
- dsram_e input 1: request
- dsram_we input 1: 1=write, 0=read
- dsram_addr input ADDR_W
- dsram_wdata input DATA_W
REQ-005 SHALL have core-side outputs:
- dsram_rdata output DATA_W: read data
- stall_req output 1: hold pipeline
- bus_err output 1: error pulse
REQ-006 SHALL have AXI4-Lite write ports:
- awvalid out 1; awready in 1; awaddr out ADDR_W
- wvalid out 1; wready in 1; wdata out DATA_W; wstrb out DATA_W/8
- bvalid in 1; bready out 1; bresp in 2
REQ-007 SHALL have AXI4-Lite read ports:
- arvalid out 1; arready in 1; araddr out ADDR_W
- rvalid in 1; rready out 1; rdata in DATA_W; rresp in 2

Function
REQ-008 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-009 In IDLE with dsram_e=1, SHALL latch addr/wdata/we and go to RD_ADDR (we=0) or WR_REQ (we=1) at the next edge.
REQ-010 stall_req SHALL be combinational: 1 in IDLE when dsram_e=1, and 1 in RD_ADDR, RD_DATA, WR_REQ and WR_RESP; 0 in IDLE when dsram_e=0, and 0 in DONE.
REQ-011 In RD_ADDR, arvalid=1 and araddr=latched address; on arready, SHALL go to RD_DATA.
REQ-012 In RD_DATA, rready=1; on rvalid, SHALL capture rdata into dsram_rdata and go to DONE.
REQ-013 In WR_REQ, awvalid and wvalid SHALL assert together.
- Each valid deasserts independently after its handshake.
- awready and wready may arrive in the same cycle or in any order.
- Go to WR_RESP once both handshakes have completed.
REQ-014 wstrb SHALL be all ones (full-word writes only); wdata SHALL equal the latched wdata.
REQ-015 In WR_RESP, bready=1; on bvalid, SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE; no new request SHALL be accepted in DONE.
REQ-017 Minimum latency with zero-wait slave: read 3 cycles of stall_req, then DONE; write 3 cycles of stall_req (IDLE, WR_REQ, WR_RESP), then DONE.
REQ-018 dsram_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-019 bus_err SHALL pulse for one cycle, in DONE, when the terminating rresp/bresp was nonzero; read data is still captured on error.
REQ-020 All AXI valid/ready outputs SHALL be registered or decoded from the state only, never combinationally from AXI inputs.
REQ-021 Core inputs SHALL be ignored outside IDLE; changing them mid-transaction SHALL have no effect.

Reset
REQ-022 On rst=1 at a clock edge, state SHALL be IDLE and all the following SHALL be 0: awvalid, wvalid, arvalid, bready, rready, bus_err, dsram_rdata, and the latched address/data.
REQ-023 Reset mid-transaction SHALL abort immediately; the slave shares this reset, so no drain is performed.

Structure
REQ-024 State encoding and the AXI response codes (OKAY=2'b00) SHALL live in the shared defines header alongside the stage bus widths.
REQ-025 SHALL be a single module with no sub-modules; the AW/W completion flags are two local registers.

Verification
REQ-026 Read, zero-wait slave:
- Stimulus: addr 0x8000_0010, rdata 0x1122_3344_5566_7788.
- Required: araddr matches, stall_req high 3 cycles, dsram_rdata = 0x1122_3344_5566_7788 in DONE.
REQ-027 Write, wready 2 cycles before awready:
- Stimulus: addr 0x8000_0020, wdata 0xDEAD_BEEF_0000_0001.
- Required: wvalid drops after its handshake, awvalid is held, WR_RESP is entered only after both, wstrb = 0xFF.
REQ-028 Read with arready delayed 4 cycles and rvalid delayed 3:
- Required: stall_req high for 9 cycles, arvalid stable throughout the wait.
REQ-029 Error response:
- Stimulus: bresp = 2'b10.
- Required: bus_err = 1 for exactly the DONE cycle, 0 otherwise.
REQ-030 Reset mid-transaction:
- Stimulus: rst asserted while in RD_DATA.
- Required: next cycle state = IDLE, all valids/readies = 0, dsram_rdata = 0.
REQ-031 Back-to-back requests (dsram_e held high):
- Stimulus: read, then write.
- Required: the write is accepted only in the IDLE cycle after DONE; the read data is unchanged by the write.
